// File: rtl/encoder_pkg.sv
// Shared types for the encoder column-parity collector.
// Frame geometry defaults, collector states and FIFO entry layout.
package encoder_pkg;

    localparam int LANES_DEFAULT  = 25;
    localparam int SLICES_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        DRAIN,
        DONE
    } collector_state_t;

    typedef struct packed {
        logic                     last;
        logic                     parity;
        logic [LANES_DEFAULT-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO with flush.
// Head is visible without a pop; push on full succeeds if a pop frees the slot.
module sync_fifo_sa #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/slice_stream_collector.sv
// Deserialises the column-parity bit stream into tagged slice words
// and presents them through a show-ahead FIFO on valid/ready.
module slice_stream_collector
    import encoder_pkg::*;
#(
    parameter int LANES      = LANES_DEFAULT,
    parameter int SLICES     = SLICES_DEFAULT,
    parameter int FIFO_DEPTH = 4,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      en,
    input  logic                      pin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES-1:0]          out_data,
    output logic                      out_parity,
    output logic                      out_last,
    output logic [$clog2(LANES)-1:0]  lane_cnt,
    output logic [$clog2(SLICES):0]   slice_cnt,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow
);

    localparam int LW = $clog2(LANES);
    localparam int SW = $clog2(SLICES) + 1;

    typedef struct packed {
        logic             last;
        logic             parity;
        logic [LANES-1:0] data;
    } entry_t;

    collector_state_t state;
    logic [LANES-1:0] shreg;
    logic [LANES-1:0] word_next;
    logic             capture;
    logic             word_end;
    logic             is_last;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    entry_t           wr_entry;
    entry_t           rd_entry;

    assign word_next = MSB_FIRST ? {shreg[LANES-2:0], pin}
                                 : {pin, shreg[LANES-1:1]};

    assign capture  = (state == CAPTURE) && en && !start;
    assign word_end = capture && (lane_cnt == LW'(LANES - 1));
    assign is_last  = (slice_cnt == SW'(SLICES - 1));
    assign pop      = out_valid && out_ready;

    assign wr_entry.last   = is_last;
    assign wr_entry.parity = ^word_next;
    assign wr_entry.data   = word_next;

    sync_fifo_sa #(
        .WIDTH (LANES + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (start),
        .push  (word_end),
        .pop   (pop),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid  = !fifo_empty;
    assign out_data   = rd_entry.data;
    assign out_parity = rd_entry.parity;
    assign out_last   = rd_entry.last;
    assign busy       = (state == CAPTURE) || (state == DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            lane_cnt  <= '0;
            slice_cnt <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else if (start) begin
            state     <= CAPTURE;
            shreg     <= '0;
            lane_cnt  <= '0;
            slice_cnt <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                CAPTURE: begin
                    if (capture) begin
                        shreg <= word_next;
                        if (word_end) begin
                            lane_cnt  <= '0;
                            slice_cnt <= slice_cnt + 1'b1;
                            // Dropped words still count so framing holds
                            if (fifo_full && !pop) overflow <= 1'b1;
                            if (is_last) state <= DRAIN;
                        end else begin
                            lane_cnt <= lane_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_stream_collector.sv
// Scoreboard bench for slice_stream_collector: framing, ordering,
// backpressure, overflow, gapped enable and abort behaviour.
module tb_slice_stream_collector;

    localparam int LANES  = 25;
    localparam int SLICES = 64;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic en = 1'b0;
    logic pin = 1'b0;
    logic out_ready = 1'b0;

    logic             out_valid, out_parity, out_last;
    logic [LANES-1:0] out_data;
    logic [4:0]       lane_cnt;
    logic [6:0]       slice_cnt;
    logic             busy, done, overflow;

    logic             m_valid, m_parity, m_last;
    logic [LANES-1:0] m_data;
    logic [4:0]       m_lane_cnt;
    logic [6:0]       m_slice_cnt;
    logic             m_busy, m_done, m_overflow;

    int vectors = 0;
    int miscompares = 0;
    int pops = 0;

    typedef struct {
        logic [LANES-1:0] data;
        logic             parity;
        logic             last;
    } exp_t;

    exp_t sb[$];
    exp_t head;

    slice_stream_collector #(
        .LANES(LANES), .SLICES(SLICES), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .en(en), .pin(pin),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_parity(out_parity), .out_last(out_last), .lane_cnt(lane_cnt),
        .slice_cnt(slice_cnt), .busy(busy), .done(done), .overflow(overflow)
    );

    slice_stream_collector #(
        .LANES(LANES), .SLICES(SLICES), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1)
    ) dut_msb (
        .clk(clk), .rst(rst), .start(start), .en(en), .pin(pin),
        .out_valid(m_valid), .out_ready(out_ready), .out_data(m_data),
        .out_parity(m_parity), .out_last(m_last), .lane_cnt(m_lane_cnt),
        .slice_cnt(m_slice_cnt), .busy(m_busy), .done(m_done),
        .overflow(m_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst && !start && out_valid) begin
            if (out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 1);
                end else begin
                    head = sb.pop_front();
                    check("word_data", out_data, head.data);
                    check("word_parity", out_parity, head.parity);
                    check("word_last", out_last, head.last);
                end
            end else if (sb.size() > 0) begin
                check("hold_data", out_data, sb[0].data);
            end
        end
    end

    task automatic send_word(input logic [LANES-1:0] val, input int idx,
                             input bit keep, input bit gaps,
                             input bit ready_last);
        exp_t e;
        for (int i = 0; i < LANES; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                en = 1'b0;
                repeat ($urandom_range(1, 2)) tick();
                check("lane_cnt_gap", lane_cnt, i);
            end
            en  = 1'b1;
            pin = val[i];
            if (i == LANES - 1) begin
                if (keep) begin
                    e.data   = val;
                    e.parity = ^val;
                    e.last   = (idx == SLICES - 1);
                    sb.push_back(e);
                end
                if (ready_last) out_ready = 1'b1;
            end
            tick();
        end
        en = 1'b0;
    endtask

    task automatic send_frame(input bit gaps);
        for (int k = 0; k < SLICES; k++)
            send_word(LANES'(k), k, 1'b1, gaps, 1'b0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check("done_reached", done, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        check("drain_empty", out_valid, 0);
    endtask

    task automatic partial_frame();
        for (int k = 0; k < 30; k++)
            send_word(LANES'(k * 7 + 3), k, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            en  = 1'b1;
            pin = i[0];
            tick();
        end
        en = 1'b0;
    endtask

    int p0;

    initial begin
        #3;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_parity", out_parity, 0);
        check("rst_last", out_last, 0);
        check("rst_lane", lane_cnt, 0);
        check("rst_slice", slice_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", overflow, 0);
        tick();
        rst = 1'b1;
        tick();

        // Bit ordering on both build variants
        out_ready = 1'b1;
        pulse_start();
        send_word(25'h1, 0, 1'b1, 1'b0, 1'b0);
        check("msb_valid", m_valid, 1);
        check("msb_data", m_data, 25'h1000000);
        check("msb_parity", m_parity, 1);
        tick();

        // Basic gap-free frame with exact done timing
        pulse_start();
        send_frame(1'b0);
        tick();
        check("done_early", done, 0);
        check("drained", out_valid, 0);
        tick();
        check("done_on_time", done, 1);
        check("busy_done", busy, 0);
        check("basic_ovf", overflow, 0);
        check("basic_slices", slice_cnt, SLICES);
        check("basic_sb", 32'(sb.size()), 0);

        // Backpressure: words 4 and 5 dropped
        pulse_start();
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++)
            send_word(LANES'(25'h0ABCDE0 ^ k), k, k < 4, 1'b0, 1'b0);
        check("bp_ovf", overflow, 1);
        check("bp_slices", slice_cnt, 6);
        check("bp_valid", out_valid, 1);
        repeat (3) tick();
        out_ready = 1'b1;
        wait_drain();

        // Full FIFO with simultaneous push and pop
        pulse_start();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++)
            send_word(LANES'(25'h1555555 >> k), k, 1'b1, 1'b0, 1'b0);
        send_word(25'h0F0F0F0, 4, 1'b1, 1'b0, 1'b1);
        out_ready = 1'b0;
        check("fpp_ovf", overflow, 0);
        check("fpp_valid", out_valid, 1);
        repeat (2) tick();
        p0 = pops;
        out_ready = 1'b1;
        wait_drain();
        check("fpp_occupancy", 32'(pops - p0), 4);

        // Gapped enable must reproduce the basic frame
        pulse_start();
        send_frame(1'b1);
        wait_done();
        check("gap_ovf", overflow, 0);
        check("gap_sb", 32'(sb.size()), 0);

        // Asynchronous reset mid-frame
        pulse_start();
        partial_frame();
        #2 rst = 1'b0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_lane", lane_cnt, 0);
        check("arst_slice", slice_cnt, 0);
        check("arst_busy", busy, 0);
        check("arst_sb", 32'(sb.size()), 0);
        tick();
        rst = 1'b1;
        tick();
        pulse_start();
        send_frame(1'b0);
        wait_done();

        // Start pulse mid-frame
        pulse_start();
        partial_frame();
        pulse_start();
        check("sabort_valid", out_valid, 0);
        check("sabort_lane", lane_cnt, 0);
        check("sabort_slice", slice_cnt, 0);
        check("sabort_busy", busy, 1);
        check("sabort_done", done, 0);
        send_frame(1'b0);
        wait_done();
        check("final_sb", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/slice_stream_collector.md
Name: slice_stream_collector

Overview:
- Parametrised successor to the column-parity capture stage of the encoder.
- Deserialises the 1-bit-per-cycle column-parity stream into LANES-bit slice words.
- Tags each word with its XOR parity and a last-slice flag, and buffers words in a small show-ahead FIFO.
- Presents words on a valid/ready interface to the downstream rotate/theta stage or a bench monitor, replacing raw per-bit dumping with counted, framed, flow-controlled output.

Parameters:
- LANES, 25, bits per slice word (lane count).
- SLICES, 64, slice words per frame.
- FIFO_DEPTH, 4, output buffer entries (power of 2, >=2).
- MSB_FIRST, 0, 0: first serial bit lands in out_data[0]; 1: first bit lands in out_data[LANES-1].

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  synchronous pulse: flush and begin a new frame.
- en  in  1  pin carries a valid serial bit this cycle.
- pin  in  1  serial data bit.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts head this cycle.
- out_data  out  LANES  slice word at FIFO head.
- out_parity  out  1  XOR of out_data.
- out_last  out  1  head word is slice SLICES-1.
- lane_cnt  out  $clog2(LANES)  bits captured in current word.
- slice_cnt  out  $clog2(SLICES)+1  words completed this frame.
- busy  out  1  state is CAPTURE or DRAIN.
- done  out  1  frame fully drained; held until start.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all counters, FIFO pointers, shift register, done and overflow are 0; out_valid=0; out_data, out_parity and out_last read 0.
- States: IDLE, CAPTURE, DRAIN, DONE.
  - IDLE/DONE -> CAPTURE on start.
  - CAPTURE -> DRAIN on the push of slice SLICES-1.
  - DRAIN -> DONE when the FIFO is empty.
  - start in any state -> CAPTURE. It clears counters, shift register, FIFO contents and overflow, and clears done. Any pop in that cycle is discarded.
- en is ignored outside CAPTURE. In CAPTURE, en=1 shifts pin into the word register in MSB_FIRST order and increments lane_cnt.
- On en with lane_cnt==LANES-1:
  - The word including the current bit, its parity, and last=(slice_cnt==SLICES-1) are pushed.
  - lane_cnt wraps to 0 and slice_cnt increments.
  - The word appears at the FIFO head, out_valid=1, in the next cycle. Latency is 1 clock from the final bit's edge.
- Pop occurs when out_valid && out_ready. The next head or empty state is visible next cycle.
- Push and pop in the same cycle:
  - Always legal, including when the FIFO is full: the pop frees the slot and the push succeeds.
  - When the FIFO is empty, the pushed word is not bypassed; it appears next cycle.
- Push with FIFO full and no pop: the word is dropped and overflow sets (sticky). slice_cnt still advances, so frame framing is preserved.
- out_data, out_parity and out_last are stable while out_valid && !out_ready.
- done asserts the cycle after DRAIN sees the FIFO empty. busy deasserts in that same cycle.
- Reset mid-frame discards everything; no partial word is ever emitted.
- Counters never exceed LANES-1 and SLICES respectively.

Decomposition:
- Shared package encoder_pkg:
  - LANES_DEFAULT=25 and SLICES_DEFAULT=64.
  - State enum collector_state_t {IDLE, CAPTURE, DRAIN, DONE}.
  - FIFO entry struct {last, parity, data}.
- Sub-module sync_fifo_sa:
  - Parametrised show-ahead FIFO, WIDTH=LANES+2, DEPTH=FIFO_DEPTH.
  - Exposes full/empty, with simultaneous push/pop on full allowed.
- Top-level module: FSM, shift register, counters, parity.

Test Plan:
- Basic frame, out_ready=1:
  - Stimulus: start, then 25x64 bits with en=1, word k = k replicated in the low 6 bits, MSB_FIRST=0.
  - Response: 64 words in order with correct parity; out_last only on word 63; done one cycle after the last pop; overflow=0.
- Bit ordering:
  - Stimulus: single word 1 followed by 24 zeros.
  - Response: out_data=0x0000001 with MSB_FIRST=0, and 0x1000000 with MSB_FIRST=1; out_parity=1.
- Backpressure and overflow:
  - Stimulus: out_ready=0 while 6 words are completed, FIFO_DEPTH=4.
  - Response: words 0-3 held stable; words 4-5 dropped; overflow=1; slice_cnt=6; words 0-3 drained intact once out_ready=1.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full, word completes in the same cycle out_ready=1.
  - Response: no drop, overflow stays 0, occupancy stays 4.
- Gapped enable:
  - Stimulus: en toggled pseudo-randomly within a frame.
  - Response: identical words to the gap-free run; lane_cnt advances only on en.
- Mid-frame abort:
  - Stimulus: rst=0 asynchronously at lane 10 of slice 30, then restart, versus a start pulse at the same point.
  - Response: both yield out_valid=0, counters 0 and an empty FIFO. The next frame is emitted cleanly with no stale word.
